// File: rtl/sixteenbit_mem_responder.sv
// Memory-side responder for the 16-bit CPU bus: word RAM with byte-lane writes,
// registered read data, and a handshaked preload port that gates the CPU reset.
//
// state | meaning
// IDLE  | CPU held in reset, waiting for load_start or run
// LOAD  | accepting preload words into RAM, CPU held in reset
// RUN   | CPU released, RAM serves the CPU bus
module sixteenbit_mem_responder #(
  parameter int AW    = 8,
  parameter int OOB_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      adr,
  input  logic [15:0]      memOut,
  input  logic             memwrite_a,
  input  logic             memwrite_b,
  output logic [15:0]      memdata,
  input  logic             load_start,
  input  logic             run,
  input  logic             load_valid,
  input  logic [15:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             load_done,
  output logic             cpu_reset,
  output logic [OOB_W-1:0] oob_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic          load_done_nx;

  logic [15:0]   mem [0:(1<<AW)-1];

  logic          in_range;
  logic          wr_any;
  logic          ram_we_lo, ram_we_hi;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          oob_hit;
  logic [15:0]   rd_nx;

  assign in_range = (adr[15:AW] == '0);
  assign wr_any   = memwrite_a | memwrite_b;

  // Single RAM write port shared between the preload path and the CPU path.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    load_done_nx = load_done;
    cpu_reset    = 1'b1;
    load_ready   = 1'b0;
    ram_we_lo    = 1'b0;
    ram_we_hi    = 1'b0;
    ram_addr     = ptr;
    ram_wdata    = load_data;
    oob_hit      = 1'b0;
    rd_nx        = 16'h0000;

    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx = LOAD;
          ptr_nx   = '0;
        end else if (run) begin
          state_nx = RUN;
        end
      end

      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_we_lo = 1'b1;
          ram_we_hi = 1'b1;
          ptr_nx    = ptr + AW'(1);
          // The top word ends the load even without load_last; no wrap to 0.
          if (load_last || (ptr == '1)) begin
            state_nx     = RUN;
            load_done_nx = 1'b1;
          end
        end
      end

      RUN: begin
        cpu_reset = 1'b0;
        if (in_range) begin
          rd_nx     = mem[adr[AW-1:0]];
          ram_we_lo = memwrite_a;
          ram_we_hi = memwrite_b;
          ram_addr  = adr[AW-1:0];
          ram_wdata = memOut;
        end else begin
          oob_hit = wr_any;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      load_done <= 1'b0;
      memdata   <= 16'h0000;
      oob_count <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      load_done <= load_done_nx;
      memdata   <= rd_nx;
      if (oob_hit && (oob_count != '1)) begin
        oob_count <= oob_count + OOB_W'(1);
      end
    end
  end

  // RAM is never cleared; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ram_we_lo) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_we_hi) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
  end

endmodule

// File: tb/tb_sixteenbit_mem_responder.sv
// Directed scoreboard bench for sixteenbit_mem_responder: stimulus pushes the
// expected output per cycle, a negedge monitor pops and compares.
module tb_sixteenbit_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr, memOut, memdata, load_data;
  logic        memwrite_a, memwrite_b, load_start, run, load_valid, load_last;
  logic        load_ready, load_done, cpu_reset;
  logic [7:0]  oob_count;

  sixteenbit_mem_responder #(.AW(8), .OOB_W(8)) dut (
    .clk(clk), .reset(reset), .adr(adr), .memOut(memOut),
    .memwrite_a(memwrite_a), .memwrite_b(memwrite_b), .memdata(memdata),
    .load_start(load_start), .run(run), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .cpu_reset(cpu_reset), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  localparam int K_MEMDATA = 0, K_READY = 1, K_DONE = 2, K_CPURST = 3, K_OOB = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    drain = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation whose cycle has come.
  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_MEMDATA: act = memdata;
          K_READY:   act = {15'd0, load_ready};
          K_DONE:    act = {15'd0, load_done};
          K_CPURST:  act = {15'd0, cpu_reset};
          default:   act = {8'd0, oob_count};
        endcase
        n_tests++;
        if (sb[i].due < cyc || act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
    if (drain) begin
      n_tests++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      drain = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input logic [15:0] exp, input string name);
    item_t it;
    it.due  = cyc;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic idle_inputs();
    adr = 16'h0; memOut = 16'h0; memwrite_a = 0; memwrite_b = 0;
    load_start = 0; run = 0; load_valid = 0; load_data = 16'h0; load_last = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic wa, input logic wb);
    adr = a; memOut = d; memwrite_a = wa; memwrite_b = wb;
    step();
    memwrite_a = 0; memwrite_b = 0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp, input string name);
    adr = a; memwrite_a = 0; memwrite_b = 0;
    step();
    expect_now(K_MEMDATA, exp, name);
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    // Reset state
    do_reset();
    expect_now(K_CPURST, 16'd1, "rst_cpu_reset");
    expect_now(K_MEMDATA, 16'h0, "rst_memdata");
    expect_now(K_READY, 16'd0, "rst_load_ready");
    expect_now(K_DONE, 16'd0, "rst_load_done");
    expect_now(K_OOB, 16'd0, "rst_oob_count");

    // Test 1: three-word preload with load_last
    load_start = 1;
    step();
    load_start = 0;
    expect_now(K_READY, 16'd1, "t1_ready_in_load");
    expect_now(K_CPURST, 16'd1, "t1_cpu_reset_in_load");
    load_valid = 1; load_data = 16'h1111; step();
    load_data = 16'h2222; step();
    expect_now(K_READY, 16'd1, "t1_ready_mid");
    load_data = 16'h3333; load_last = 1; step();
    load_valid = 0; load_last = 0;
    expect_now(K_DONE, 16'd1, "t1_load_done");
    expect_now(K_CPURST, 16'd0, "t1_cpu_released");
    expect_now(K_READY, 16'd0, "t1_ready_in_run");
    cpu_read(16'd1, 16'h2222, "t1_read_mem1");
    cpu_read(16'd0, 16'h1111, "t1_read_mem0");

    // Test 2: byte-lane writes
    cpu_write(16'd5, 16'h0000, 1, 1);
    cpu_write(16'd5, 16'hABCD, 1, 0);
    expect_now(K_MEMDATA, 16'h0000, "t2_rbw_low");
    cpu_write(16'd5, 16'h12EF, 0, 1);
    expect_now(K_MEMDATA, 16'h00CD, "t2_rbw_high");
    cpu_read(16'd5, 16'h12CD, "t2_byte_lanes");

    // Test 3: read-before-write on the same address
    cpu_write(16'd7, 16'h0001, 1, 1);
    cpu_write(16'd7, 16'hBEEF, 1, 1);
    expect_now(K_MEMDATA, 16'h0001, "t3_old_data");
    cpu_read(16'd7, 16'hBEEF, "t3_new_data");

    // Test 4: out-of-range writes saturate the counter and leave RAM alone
    cpu_write(16'h0100, 16'hDEAD, 1, 1);
    expect_now(K_OOB, 16'd1, "t4_oob_first");
    expect_now(K_MEMDATA, 16'h0000, "t4_oob_read_zero");
    for (int i = 1; i < 300; i++) cpu_write(16'h0100, 16'hDEAD, (i % 2) == 0, 1);
    expect_now(K_OOB, 16'd255, "t4_oob_saturated");
    cpu_read(16'h0100, 16'h0000, "t4_read_oob_addr");
    cpu_read(16'h0000, 16'h1111, "t4_mem0_untouched");
    cpu_read(16'h8005, 16'h0000, "t4_high_addr_read");

    // Test 5: full-depth preload without load_last, with one idle gap
    do_reset();
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        load_valid = 0; load_data = 16'hFFFF; step();
      end
      load_valid = 1; load_data = 16'h4000 + 16'(i); step();
      if (i == 254) expect_now(K_READY, 16'd1, "t5_ready_before_top");
    end
    load_valid = 0;
    expect_now(K_CPURST, 16'd0, "t5_exit_at_top");
    expect_now(K_DONE, 16'd1, "t5_load_done");
    load_valid = 1; load_data = 16'hFFFF; step(); load_valid = 0;
    cpu_read(16'd255, 16'h40FF, "t5_mem255");
    cpu_read(16'd0, 16'h4000, "t5_mem0_no_wrap");
    cpu_read(16'd101, 16'h4065, "t5_gap_no_skip");

    // Test 6: reset mid-load, IDLE ignores writes, then run
    do_reset();
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = 16'hC001; step();
    load_data = 16'hC002; step();
    load_valid = 0; reset = 1; step(); reset = 0;
    expect_now(K_READY, 16'd0, "t6_ready_after_reset");
    expect_now(K_CPURST, 16'd1, "t6_cpu_reset_idle");
    expect_now(K_DONE, 16'd0, "t6_done_cleared");
    cpu_write(16'd3, 16'h9999, 1, 1);
    expect_now(K_MEMDATA, 16'h0000, "t6_idle_memdata");
    cpu_write(16'h0200, 16'h9999, 1, 1);
    run = 1; step(); run = 0;
    expect_now(K_CPURST, 16'd0, "t6_run_released");
    expect_now(K_DONE, 16'd0, "t6_done_still_zero");
    load_valid = 1; load_data = 16'hEEEE; step(); load_valid = 0;
    expect_now(K_READY, 16'd0, "t6_ready_in_run");
    cpu_read(16'd0, 16'hC001, "t6_mem0_kept");
    cpu_read(16'd1, 16'hC002, "t6_mem1_kept");
    cpu_read(16'd2, 16'h4002, "t6_mem2_untouched");
    cpu_read(16'd3, 16'h4003, "t6_idle_write_ignored");
    expect_now(K_OOB, 16'd0, "t6_idle_oob_not_counted");

    // Reset in RUN reasserts cpu_reset at the next edge
    reset = 1; step(); reset = 0;
    expect_now(K_CPURST, 16'd1, "t6_reset_in_run");

    step();
    drain = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
